// File: rtl/atm_pkg.sv
// Shared encodings for the ATM front-panel controller: card status, menu commands and FSM states.
package atm_pkg;

    localparam logic [1:0] CARD_NONE    = 2'b00;
    localparam logic [1:0] CARD_INVALID = 2'b01;
    localparam logic [1:0] CARD_VALID   = 2'b10;

    localparam logic [2:0] MENU_NONE     = 3'b000;
    localparam logic [2:0] MENU_BALANCE  = 3'b001;
    localparam logic [2:0] MENU_RAPID    = 3'b010;
    localparam logic [2:0] MENU_WITHDRAW = 3'b011;
    localparam logic [2:0] MENU_DEPOSIT  = 3'b100;
    localparam logic [2:0] MENU_EXIT     = 3'b101;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REJECT  = 3'd1;
    localparam logic [2:0] ST_PIN     = 3'd2;
    localparam logic [2:0] ST_SESSION = 3'd3;
    localparam logic [2:0] ST_AMOUNT  = 3'd4;
    localparam logic [2:0] ST_ISSUE   = 3'd5;
    localparam logic [2:0] ST_GAP     = 3'd6;

    typedef struct packed {
        logic card;
        logic cancel;
        logic enter;
        logic next;
    } press_t;

    // The card stays valid through ISSUE/GAP so an exit only drops it on IDLE entry.
    function automatic logic [1:0] card_code(input logic [2:0] st);
        case (st)
            ST_REJECT:                                 card_code = CARD_INVALID;
            ST_SESSION, ST_AMOUNT, ST_ISSUE, ST_GAP:   card_code = CARD_VALID;
            ST_IDLE, ST_PIN:                           card_code = CARD_NONE;
            default:                                   card_code = CARD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/atm_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, stable-count debouncer and rising-edge press pulse.
module atm_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    logic [1:0]  sync;
    logic [15:0] count;
    logic        level;

    // The level flips on the Nth consecutive differing sample; a rising flip is the press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b00;
            count <= 16'd0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                count <= 16'd0;
            end else if (count == DEBOUNCE_CYCLES - 16'd1) begin
                count <= 16'd0;
                level <= sync[1];
                press <= sync[1];
            end else begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/atm_input_ctrl.sv
// ATM front-panel controller: debounced buttons drive a card/menu FSM issuing one-cycle commands.
// Optional PIN entry stage is enabled by defining ATM_PIN_EN.
module atm_input_ctrl
    import atm_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [7:0]  RAPID_AMOUNT    = 8'd20,
    parameter logic [7:0]  PIN_CODE        = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_card,
    input  logic       sw_card_ok,
    input  logic       btn_next,
    input  logic       btn_enter,
    input  logic       btn_cancel,
    input  logic [7:0] sw_amount,
    output logic [1:0] card_input,
    output logic [2:0] menu_input,
    output logic [7:0] deposit_amount,
    output logic [7:0] withdraw_amount,
    output logic [2:0] sel_item,
    output logic       amount_mode
);

    logic   p_card, p_next, p_enter, p_cancel;
    press_t press;
    logic [2:0] state;
    logic [2:0] cmd;
    logic       gap_cnt;
`ifdef ATM_PIN_EN
    logic [1:0] pin_fail;
`endif

    atm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_card   (.clk(clk), .rst(rst), .raw(btn_card),   .press(p_card));
    atm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next   (.clk(clk), .rst(rst), .raw(btn_next),   .press(p_next));
    atm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter  (.clk(clk), .rst(rst), .raw(btn_enter),  .press(p_enter));
    atm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (.clk(clk), .rst(rst), .raw(btn_cancel), .press(p_cancel));

    // Only the highest-priority press of a cycle survives.
    always_comb begin
        press = '0;
        if (p_card)        press.card   = 1'b1;
        else if (p_cancel) press.cancel = 1'b1;
        else if (p_enter)  press.enter  = 1'b1;
        else if (p_next)   press.next   = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_IDLE;
            cmd             <= MENU_NONE;
            gap_cnt         <= 1'b0;
            sel_item        <= 3'd1;
            withdraw_amount <= 8'd0;
            deposit_amount  <= 8'd0;
`ifdef ATM_PIN_EN
            pin_fail        <= 2'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
`ifdef ATM_PIN_EN
                    pin_fail <= 2'd0;
`endif
                    if (press.card) begin
                        if (sw_card_ok) begin
`ifdef ATM_PIN_EN
                            state <= ST_PIN;
`else
                            state    <= ST_SESSION;
                            sel_item <= 3'd1;
`endif
                        end else begin
                            state <= ST_REJECT;
                        end
                    end
                end
                ST_REJECT: begin
                    if (press.card) begin
                        state    <= ST_IDLE;
                        sel_item <= 3'd1;
                    end
                end
`ifdef ATM_PIN_EN
                ST_PIN: begin
                    if (press.card || press.cancel) begin
                        state <= ST_IDLE;
                    end else if (press.enter) begin
                        if (sw_amount == PIN_CODE) begin
                            state    <= ST_SESSION;
                            sel_item <= 3'd1;
                        end else if (pin_fail == 2'd2) begin
                            state <= ST_REJECT;
                        end else begin
                            pin_fail <= pin_fail + 2'd1;
                        end
                    end
                end
`endif
                ST_SESSION: begin
                    if (press.card || press.cancel) begin
                        cmd   <= MENU_EXIT;
                        state <= ST_ISSUE;
                    end else if (press.enter) begin
                        case (sel_item)
                            3'd1: begin
                                cmd   <= MENU_BALANCE;
                                state <= ST_ISSUE;
                            end
                            3'd2: begin
                                withdraw_amount <= RAPID_AMOUNT;
                                cmd             <= MENU_RAPID;
                                state           <= ST_ISSUE;
                            end
                            3'd3, 3'd4: state <= ST_AMOUNT;
                            default: begin
                                cmd   <= MENU_EXIT;
                                state <= ST_ISSUE;
                            end
                        endcase
                    end else if (press.next) begin
                        sel_item <= (sel_item == 3'd5) ? 3'd1 : sel_item + 3'd1;
                    end
                end
                ST_AMOUNT: begin
                    if (press.card) begin
                        cmd   <= MENU_EXIT;
                        state <= ST_ISSUE;
                    end else if (press.cancel) begin
                        state    <= ST_SESSION;
                        sel_item <= 3'd1;
                    end else if (press.enter) begin
                        if (sel_item == 3'd3) begin
                            withdraw_amount <= sw_amount;
                            cmd             <= MENU_WITHDRAW;
                        end else begin
                            deposit_amount <= sw_amount;
                            cmd            <= MENU_DEPOSIT;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    gap_cnt <= 1'b0;
                    state   <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt) begin
                        state    <= (cmd == MENU_EXIT) ? ST_IDLE : ST_SESSION;
                        sel_item <= 3'd1;
                    end else begin
                        gap_cnt <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign card_input  = card_code(state);
    assign menu_input  = (state == ST_ISSUE) ? cmd : MENU_NONE;
    assign amount_mode = (state == ST_AMOUNT);

endmodule

// File: tb/tb_atm_input_ctrl.sv
// Self-checking bench for atm_input_ctrl: vector table of button steps plus cycle-exact exit, reset and PIN sequences.
module tb_atm_input_ctrl;

    localparam int OP_CARD   = 0;
    localparam int OP_NEXT   = 1;
    localparam int OP_ENTER  = 2;
    localparam int OP_CANCEL = 3;
    localparam int OP_GLITCH = 4;
    localparam int OP_VALID  = 5;

    typedef struct {
        int         op;
        logic       card_ok;
        logic [7:0] amount;
        logic [1:0] exp_card;
        logic [2:0] exp_cmd;
        logic [2:0] exp_sel;
        logic       exp_mode;
        logic [7:0] exp_wd;
        logic [7:0] exp_dep;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_card = 1'b0, sw_card_ok = 1'b0, btn_next = 1'b0, btn_enter = 1'b0, btn_cancel = 1'b0;
    logic [7:0] sw_amount = 8'd0;
    logic [1:0] card_input;
    logic [2:0] menu_input;
    logic [7:0] deposit_amount, withdraw_amount;
    logic [2:0] sel_item;
    logic       amount_mode;

    int         tests = 0;
    int         fails = 0;
    logic [2:0] expq[$];
    logic [2:0] mon_exp;
    vec_t       vecs[$];
    bit         seen;

    atm_input_ctrl #(.DEBOUNCE_CYCLES(16'd4), .RAPID_AMOUNT(8'd20), .PIN_CODE(8'h5A)) dut (
        .clk(clk), .rst(rst), .btn_card(btn_card), .sw_card_ok(sw_card_ok),
        .btn_next(btn_next), .btn_enter(btn_enter), .btn_cancel(btn_cancel),
        .sw_amount(sw_amount), .card_input(card_input), .menu_input(menu_input),
        .deposit_amount(deposit_amount), .withdraw_amount(withdraw_amount),
        .sel_item(sel_item), .amount_mode(amount_mode)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard: every nonzero command must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && menu_input != 3'b000) begin
            tests++;
            if (expq.size() == 0) begin
                fails++;
                $display("[TB] FAIL cmd_unexpected: got %0d, required none", menu_input);
            end else begin
                mon_exp = expq.pop_front();
                if (mon_exp != menu_input) begin
                    fails++;
                    $display("[TB] FAIL cmd_code: got %0d, required %0d", menu_input, mon_exp);
                end
            end
        end
    end

    task automatic checkVal(input string name, input int actual, input int required);
        tests++;
        if (actual != required) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic pressButton(input int which);
        @(negedge clk);
        case (which)
            OP_CARD:   btn_card   = 1'b1;
            OP_NEXT:   btn_next   = 1'b1;
            OP_ENTER:  btn_enter  = 1'b1;
            default:   btn_cancel = 1'b1;
        endcase
        repeat (8) @(negedge clk);
        btn_card = 1'b0; btn_next = 1'b0; btn_enter = 1'b0; btn_cancel = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic addVec(input int op, input logic ok, input logic [7:0] amt, input logic [1:0] card,
                          input logic [2:0] cmd, input logic [2:0] sel, input logic mode,
                          input logic [7:0] wd, input logic [7:0] dep);
        vec_t v;
        v.op = op; v.card_ok = ok; v.amount = amt; v.exp_card = card; v.exp_cmd = cmd;
        v.exp_sel = sel; v.exp_mode = mode; v.exp_wd = wd; v.exp_dep = dep;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        sw_amount  = v.amount;
        sw_card_ok = v.card_ok;
        if (v.exp_cmd != 3'b000) expq.push_back(v.exp_cmd);
        case (v.op)
            OP_GLITCH: begin
                @(negedge clk);
                btn_enter = 1'b1;
                repeat (3) @(negedge clk);
                btn_enter = 1'b0;
                repeat (12) @(negedge clk);
            end
            OP_VALID: begin
                sw_card_ok = 1'b1;
                pressButton(OP_CARD);
`ifdef ATM_PIN_EN
                sw_amount = 8'h5A;
                pressButton(OP_ENTER);
`endif
            end
            default: pressButton(v.op);
        endcase
    endtask

    task automatic checkOutput(input string name, input vec_t v);
        checkVal({name, "_card"},  card_input,      v.exp_card);
        checkVal({name, "_sel"},   sel_item,        v.exp_sel);
        checkVal({name, "_mode"},  amount_mode,     v.exp_mode);
        checkVal({name, "_wd"},    withdraw_amount, v.exp_wd);
        checkVal({name, "_dep"},   deposit_amount,  v.exp_dep);
        checkVal({name, "_pending"}, expq.size(),   0);
    endtask

    task automatic waitCommand(input string name);
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (menu_input != 3'b000) begin
                seen = 1'b1;
                break;
            end
        end
        checkVal(name, seen, 1);
    endtask

    initial begin
        // op, ok, amount, card, cmd, sel, mode, withdraw, deposit
        addVec(OP_VALID,  1, 8'd0,  2'b10, 3'b000, 3'd1, 0, 8'd0,  8'd0);
        addVec(OP_GLITCH, 1, 8'd0,  2'b10, 3'b000, 3'd1, 0, 8'd0,  8'd0);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd2, 0, 8'd0,  8'd0);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd3, 0, 8'd0,  8'd0);
        addVec(OP_ENTER,  1, 8'd0,  2'b10, 3'b000, 3'd3, 1, 8'd0,  8'd0);
        addVec(OP_ENTER,  1, 8'd35, 2'b10, 3'b011, 3'd1, 0, 8'd35, 8'd0);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd2, 0, 8'd35, 8'd0);
        addVec(OP_ENTER,  1, 8'd0,  2'b10, 3'b010, 3'd1, 0, 8'd20, 8'd0);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd2, 0, 8'd20, 8'd0);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd3, 0, 8'd20, 8'd0);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd4, 0, 8'd20, 8'd0);
        addVec(OP_ENTER,  1, 8'd0,  2'b10, 3'b000, 3'd4, 1, 8'd20, 8'd0);
        addVec(OP_ENTER,  1, 8'd77, 2'b10, 3'b100, 3'd1, 0, 8'd20, 8'd77);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd2, 0, 8'd20, 8'd77);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd3, 0, 8'd20, 8'd77);
        addVec(OP_ENTER,  1, 8'd0,  2'b10, 3'b000, 3'd3, 1, 8'd20, 8'd77);
        addVec(OP_CANCEL, 1, 8'd99, 2'b10, 3'b000, 3'd1, 0, 8'd20, 8'd77);
        addVec(OP_ENTER,  1, 8'd99, 2'b10, 3'b001, 3'd1, 0, 8'd20, 8'd77);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd2, 0, 8'd20, 8'd77);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd3, 0, 8'd20, 8'd77);
        addVec(OP_ENTER,  1, 8'd0,  2'b10, 3'b000, 3'd3, 1, 8'd20, 8'd77);
        addVec(OP_CARD,   1, 8'd0,  2'b00, 3'b101, 3'd1, 0, 8'd20, 8'd77);
        addVec(OP_CARD,   0, 8'd0,  2'b01, 3'b000, 3'd1, 0, 8'd20, 8'd77);
        addVec(OP_NEXT,   0, 8'd0,  2'b01, 3'b000, 3'd1, 0, 8'd20, 8'd77);
        addVec(OP_CARD,   0, 8'd0,  2'b00, 3'b000, 3'd1, 0, 8'd20, 8'd77);
        addVec(OP_VALID,  1, 8'd0,  2'b10, 3'b000, 3'd1, 0, 8'd20, 8'd77);
        addVec(OP_CANCEL, 1, 8'd0,  2'b00, 3'b101, 3'd1, 0, 8'd20, 8'd77);
        addVec(OP_VALID,  1, 8'd0,  2'b10, 3'b000, 3'd1, 0, 8'd20, 8'd77);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd2, 0, 8'd20, 8'd77);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd3, 0, 8'd20, 8'd77);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd4, 0, 8'd20, 8'd77);
        addVec(OP_NEXT,   1, 8'd0,  2'b10, 3'b000, 3'd5, 0, 8'd20, 8'd77);
        addVec(OP_ENTER,  1, 8'd0,  2'b00, 3'b101, 3'd1, 0, 8'd20, 8'd77);

        repeat (3) @(negedge clk);
        checkVal("reset_card", card_input,      0);
        checkVal("reset_menu", menu_input,      0);
        checkVal("reset_wd",   withdraw_amount, 0);
        checkVal("reset_dep",  deposit_amount,  0);
        checkVal("reset_sel",  sel_item,        1);
        checkVal("reset_mode", amount_mode,     0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d", i), vecs[i]);
        end

        // Exit from AMOUNT: card stays valid for both gap cycles, then drops.
        applyStimulus(vecs[0]);
        pressButton(OP_NEXT);
        pressButton(OP_NEXT);
        pressButton(OP_ENTER);
        checkVal("amt_mode_before_exit", amount_mode, 1);
        expq.push_back(3'b101);
        @(negedge clk);
        btn_card = 1'b1;
        waitCommand("exit_seen");
        @(negedge clk);
        checkVal("gap1_menu", menu_input, 0);
        checkVal("gap1_card", card_input, 2);
        @(negedge clk);
        checkVal("gap2_card", card_input, 2);
        @(negedge clk);
        checkVal("idle_card", card_input, 0);
        btn_card = 1'b0;
        repeat (12) @(negedge clk);

        // Reset during the gap after an exit.
        applyStimulus(vecs[0]);
        expq.push_back(3'b101);
        @(negedge clk);
        btn_cancel = 1'b1;
        waitCommand("cancel_seen");
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkVal("rst_gap_card", card_input,      0);
        checkVal("rst_gap_menu", menu_input,      0);
        checkVal("rst_gap_wd",   withdraw_amount, 0);
        checkVal("rst_gap_dep",  deposit_amount,  0);
        checkVal("rst_gap_sel",  sel_item,        1);
        checkVal("rst_gap_mode", amount_mode,     0);
        @(negedge clk);
        rst = 1'b0;
        btn_cancel = 1'b0;
        repeat (20) @(negedge clk);
        checkVal("post_rst_card", card_input, 0);
        checkVal("post_rst_pending", expq.size(), 0);

`ifdef ATM_PIN_EN
        sw_card_ok = 1'b1;
        pressButton(OP_CARD);
        checkVal("pin_entry_card", card_input, 0);
        sw_amount = 8'h11;
        pressButton(OP_ENTER);
        checkVal("pin_bad1_card", card_input, 0);
        pressButton(OP_ENTER);
        checkVal("pin_bad2_card", card_input, 0);
        pressButton(OP_ENTER);
        checkVal("pin_bad3_card", card_input, 1);
        pressButton(OP_CARD);
        checkVal("pin_reject_out", card_input, 0);
        pressButton(OP_CARD);
        sw_amount = 8'h11;
        pressButton(OP_ENTER);
        sw_amount = 8'h5A;
        pressButton(OP_ENTER);
        checkVal("pin_ok_card", card_input, 2);
        checkVal("pin_ok_sel",  sel_item,   1);
        expq.push_back(3'b101);
        pressButton(OP_CANCEL);
        checkVal("pin_exit_card", card_input, 0);
        checkVal("pin_exit_pending", expq.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
